lsu_mem_port: RTL
=================

# lsu_mem_port

Load/store initiator that drives the word-wide `Data_Memory` port (`wr_en`, `rd_en`, `address`, `wdata`, `rdata`) on behalf of the core's memory stage. It accepts one byte/half/word load or store at a time over a valid/ready request channel. Sub-word stores are done as read-modify-write, and load data is sign- or zero-extended. The block sits between the pipeline's MEM stage and the data memory, and is the only master of that memory.

## Interface
- `ADDR_W`, 32: request/memory address width
- `DATA_W`, 32: data width (fixed 32, parameter for documentation only)
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  synchronous reset, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  high only in IDLE; transfer on `req_valid && req_ready`
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved
- `req_unsigned`  in  1  load zero-extends when 1
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  DATA_W  store data, right-justified
- `resp_valid`  out  1  one-cycle completion pulse, no backpressure
- `resp_rdata`  out  DATA_W  extended load data; 0 for stores and errors
- `resp_err`  out  1  misaligned or reserved size (valid with `resp_valid`)
- `mem_wr_en`, `mem_rd_en`  out  1  memory strobes, never both high
- `mem_address`  out  ADDR_W  `{req_addr[31:2],2'b00}` (registered copy)
- `mem_wdata`  out  DATA_W  full merged word
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- States: IDLE, READ, MERGE, WRITE, RESP. On accept, the request is latched into internal registers and the core inputs are ignored until the next IDLE.
- Load: IDLE → READ (`mem_rd_en`=1) → MERGE (capture `mem_rdata`, select lane by `addr[1:0]`, extend) → RESP → IDLE.
- Word store: IDLE → WRITE (`mem_wr_en`=1, `mem_wdata`=`req_wdata`) → RESP → IDLE.
- Byte/half store: IDLE → READ → MERGE (replace the addressed lane of the captured word) → WRITE → RESP → IDLE.
- Byte lane = `addr[1:0]`. Half lane = `addr[1]`.
- Error (misaligned or size 11, when checking is enabled): IDLE → RESP with `resp_err`=1. No memory strobe is issued.
- Strobes are decoded from state and gated with `!rst`, so no memory access occurs in any cycle where `rst` is high.

## Timing
- Reset values: `req_ready`=0 while `rst` is high, 1 from the first cycle after. All other outputs are 0 and state is IDLE.
- Accept-to-`resp_valid` latency: load 3, word store 2, sub-word store 4, error 1 cycles.
- Memory read latency is 1: `mem_rdata` is sampled in MERGE, the cycle after READ. Writes commit on the WRITE-cycle edge.
- A load following a store to the same address is accepted no earlier than the cycle after RESP, so it sees the written data.
- `req_ready` drops the cycle after accept. It returns high the cycle after RESP, giving a back-to-back throughput of one request per latency+1 cycles.
- Reset asserted in any state aborts the operation with no response. A sub-word store aborted in READ or MERGE leaves memory unchanged.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - half with `addr[0]`=1 sets `resp_err`.
  - word with `addr[1:0]`≠0 sets `resp_err`.
  - size 11 sets `resp_err`.
- `LSU_ALIGN_CHECK_EN` undefined:
  - `resp_err` is tied to 0.
  - Offending low address bits are ignored (half uses `addr[1]`, word forces lane 0).
  - Size 11 is treated as a word access.

## Structure
- Package `lsu_pkg`:
  - size encodings `SZ_B`/`SZ_H`/`SZ_W`
  - state enum `lsu_state_t`
  - `WORD_BYTES`=4
- Sub-module `lsu_byte_lane`: purely combinational.
  - Extract: rdata + offset + size + unsigned → extended data.
  - Merge: old word + wdata + offset + size → new word.
  - The FSM remains in `lsu_mem_port`.

## Test plan
- Word store 0xA5A5A5A5 @0x04, then word load @0x04 → `resp_rdata`=0xA5A5A5A5, with `resp_valid` 2 and 3 cycles after the respective accepts.
- Word 0x12345678 @0x10, then byte store 0xEF @0x11 → memory word 0x1234EF78. Signed byte load @0x11 → 0xFFFFFFEF. Unsigned → 0x000000EF.
- Half store 0xBEEF @0x22 into a zeroed word → memory 0xBEEF0000. Signed half load @0x22 → 0xFFFFBEEF. Unsigned half load @0x20 → 0x00000000.
- Word load @0x06 with `LSU_ALIGN_CHECK_EN` → `resp_err`=1 one cycle after accept, with no `mem_rd_en` pulse. Without the macro → data of word 0x04, `resp_err`=0.
- `rst` pulsed during MERGE of a byte store to 0x31 over 0xCAFEF00D → no `mem_wr_en`, no `resp_valid`, word still 0xCAFEF00D, `req_ready`=1 the cycle after `rst` falls.
- `req_valid` held high for two loads → second accepted exactly the cycle after the first RESP, `req_ready` low in between, and `mem_wr_en`/`mem_rd_en` never high together.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store memory port.
// Size codes, FSM state type and word geometry.
package lsu_pkg;

    localparam int WORD_BYTES = 4;
    localparam int OFF_W      = $clog2(WORD_BYTES);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_MERGE,
        ST_WRITE,
        ST_RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_mem_port_byte_lane.sv
// Combinational lane extract/extend and sub-word merge.
// Byte lane = off, half lane = off[1], word (or size 11) = whole word.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0]      i_rdata,
    input  logic [31:0]      i_wdata,
    input  logic [OFF_W-1:0] i_off,
    input  logic [1:0]       i_size,
    input  logic             i_unsigned,
    output logic [31:0]      o_ext,
    output logic [31:0]      o_merged
);

    logic [7:0]  w_b;
    logic [15:0] w_h;

    // Select the addressed lane, extend it, and build the merged word.
    always_comb begin
        w_b      = 8'h00;
        w_h      = 16'h0000;
        o_ext    = i_rdata;
        o_merged = i_wdata;
        case (i_size)
            SZ_B: begin
                o_merged = i_rdata;
                case (i_off)
                    2'd0: begin w_b = i_rdata[7:0];   o_merged[7:0]   = i_wdata[7:0]; end
                    2'd1: begin w_b = i_rdata[15:8];  o_merged[15:8]  = i_wdata[7:0]; end
                    2'd2: begin w_b = i_rdata[23:16]; o_merged[23:16] = i_wdata[7:0]; end
                    default: begin w_b = i_rdata[31:24]; o_merged[31:24] = i_wdata[7:0]; end
                endcase
                o_ext = i_unsigned ? {24'h0, w_b} : {{24{w_b[7]}}, w_b};
            end
            SZ_H: begin
                o_merged = i_rdata;
                if (i_off[1]) begin
                    w_h = i_rdata[31:16];
                    o_merged[31:16] = i_wdata[15:0];
                end else begin
                    w_h = i_rdata[15:0];
                    o_merged[15:0] = i_wdata[15:0];
                end
                o_ext = i_unsigned ? {16'h0, w_h} : {{16{w_h[15]}}, w_h};
            end
            default: begin
                o_ext    = i_rdata;
                o_merged = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator and sole master of the word-wide data memory.
// Define LSU_ALIGN_CHECK_EN to flag misaligned / reserved-size requests.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_t        r_state;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [OFF_W-1:0]  r_off;
    logic [ADDR_W-3:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_err;
    logic              w_sub_in;
    logic [31:0]       w_ext;
    logic [31:0]       w_merged;

    // Request error decode; without checking, bad alignment is ignored.
    always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
        w_err = (req_size == SZ_H && req_addr[0])
             || (req_size == SZ_W && req_addr[1:0] != 2'b00)
             || (req_size == 2'b11);
`else
        w_err = 1'b0;
`endif
    end

    assign w_sub_in = (req_size == SZ_B) || (req_size == SZ_H);

    lsu_byte_lane u_lane (
        .i_rdata    (mem_rdata),
        .i_wdata    (r_wdata),
        .i_off      (r_off),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_ext      (w_ext),
        .o_merged   (w_merged)
    );

    // Main FSM: latch request, sequence memory strobes, hold response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_size  <= SZ_B;
            r_uns   <= 1'b0;
            r_off   <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_uns   <= req_unsigned;
                        r_off   <= req_addr[OFF_W-1:0];
                        r_waddr <= req_addr[ADDR_W-1:2];
                        r_wdata <= req_wdata;
                        r_rdata <= '0;
                        r_err   <= w_err;
                        if (w_err)
                            r_state <= ST_RESP;
                        else if (req_we && !w_sub_in)
                            r_state <= ST_WRITE;
                        else
                            r_state <= ST_READ;
                    end
                end
                ST_READ: r_state <= ST_MERGE;
                ST_MERGE: begin
                    if (r_we) begin
                        r_wdata <= w_merged;
                        r_state <= ST_WRITE;
                    end else begin
                        r_rdata <= w_ext;
                        r_state <= ST_RESP;
                    end
                end
                ST_WRITE: r_state <= ST_RESP;
                ST_RESP: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = (r_state == ST_IDLE) && !rst;
    assign mem_rd_en   = (r_state == ST_READ) && !rst;
    assign mem_wr_en   = (r_state == ST_WRITE) && !rst;
    assign resp_valid  = (r_state == ST_RESP) && !rst;
    assign resp_rdata  = r_rdata;
    assign resp_err    = r_err;
    assign mem_address = {r_waddr, 2'b00};
    assign mem_wdata   = r_wdata;

endmodule
